axi_lite_ctrl_regs: RTL and testbench
=====================================

# axi_lite_ctrl_regs

AXI4-Lite slave register bank placed between the AXI VIP master (or the PS interconnect) and an HLS-generated core: it terminates the S00_AXI bus, holds four general registers plus HLS-style block-control and argument registers, and drives the core's ap_start/argument handshake. It is the slave stage that consumes the master's AXI4-Lite write/read bursts.

## Interface
- ADDR_W, 5: byte-address width; word-aligned map 0x00–0x1C.
- RESET_ARG, 32'h0: reset value of ARG registers.
- ACLK  in  1  single clock; all logic rising-edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR / S_AXI_ARADDR  in  ADDR_W  write/read address; bits [1:0] ignored.
- S_AXI_AWPROT / S_AXI_ARPROT  in  3  accepted, ignored.
- S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY  in  1  AXI handshakes.
- S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID  out  1  AXI handshakes.
- S_AXI_WDATA  in  32  write data; S_AXI_WSTRB  in  4  byte enables.
- S_AXI_BRESP / S_AXI_RRESP  out  2  OKAY (00) or SLVERR (10).
- S_AXI_RDATA  out  32  read data.
- ap_start  out  1  core start request.
- ap_done, ap_ready, ap_idle  in  1  core status.
- arg  out  96  {ARG2,ARG1,ARG0}.
- result  in  32  core result, sampled on ap_done.

## Operation
- Map: 0x00 GP0, 0x04 GP1, 0x08 GP2, 0x0C GP3 (RW, reset 0); 0x10 CTRL; 0x14 ARG0, 0x18 ARG1 (RW, reset RESET_ARG); 0x1C RESULT (RO). ARG2 lives at GP3's shadow? No: ARG2 = GP3 (same flop).
- CTRL bits: [0] ap_start (W1 sets; RW read-back), [1] ap_done (sticky, RO, clear-on-read), [2] ap_idle (live, RO), [3] ap_ready (live, RO), [7] auto_restart (RW); other bits read 0, writes ignored.
- Writes honour WSTRB per byte; CTRL write affects only bits 0 (set only, writing 0 has no effect) and 7.
- Write to RESULT: ignored, BRESP OKAY. Address beyond map cannot occur with ADDR_W=5; for larger ADDR_W, addresses ≥0x20: write dropped, read RDATA=0, resp SLVERR.
- ap_start clears the cycle after ap_ready=1 unless auto_restart=1; ap_done latch sets when ap_done=1, RESULT captures result same edge.
- ap_done latch clears on the AR handshake of a CTRL read (the returned RDATA shows 1); if ap_done input is 1 that same cycle, set wins.
- Write FSM: IDLE → (AW and/or W captured, each held independently) → both held → commit, BVALID → BREADY → IDLE. Only one write outstanding.
- Read FSM: IDLE → AR handshake → RVALID held until RREADY → IDLE. Only one read outstanding; reads and writes independent.

## Timing
- Reset: all AXI outputs 0, RDATA 0, BRESP/RRESP 00, ap_start 0, all registers at reset values; AWREADY/WREADY/ARREADY first high the cycle after ARESET deasserts.
- AWREADY high iff no address held and BVALID low; WREADY likewise for data. AW and W may arrive in either order or same cycle.
- Last of AW/W handshaked at edge N → register updated and BVALID high at N+1; held until BREADY.
- AR handshake at N → RVALID, RDATA, RRESP valid at N+1; ARREADY low while RVALID high; RDATA stable until RREADY.
- Simultaneous write commit and read of same address: read returns pre-write value.
- ARESET mid-transaction: pending AW/W/B/R dropped at once, outputs to reset values next edge.

## Structure
- Package axi_lite_ctrl_pkg: register offset localparams, CTRL bit indices, resp_t enum (OKAY, SLVERR).
- One sub-module natural: axi_lite_ctrl_core_if (ap_start/ap_done latching, RESULT capture); AXI FSMs stay in top.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x00–0x0C, read back → RDATA 1,2,3,4, RRESP OKAY each.
- W issued 3 cycles before AW to 0x14, data 0xDEADBEEF → BVALID one cycle after AW; arg[31:0]=0xDEADBEEF.
- Write 0xFFFFFFFF with WSTRB=4'b0101 to 0x04 (prior 0) → reads 0x00FF00FF.
- Write CTRL=0x1; pulse ap_ready, then ap_done with result=0x1234 → ap_start falls after ap_ready; CTRL reads 0x2|idle bit; second CTRL read shows bit1=0; RESULT=0x1234.
- auto_restart=1 with ap_start, pulse ap_ready → ap_start stays 1.
- BREADY/RREADY held low 10 cycles → BVALID/RVALID and data stable, no new AW/AR accepted; ARESET asserted mid-wait → all outputs 0 next edge.

Source files
------------

// File: rtl/axi_lite_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite control register bank.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package axi_lite_ctrl_pkg;

  // Byte offsets of the register map (bits [1:0] always ignored)
  localparam logic [4:0] OFF_GP0    = 5'h00;
  localparam logic [4:0] OFF_GP1    = 5'h04;
  localparam logic [4:0] OFF_GP2    = 5'h08;
  localparam logic [4:0] OFF_GP3    = 5'h0C; // also drives ARG2
  localparam logic [4:0] OFF_CTRL   = 5'h10;
  localparam logic [4:0] OFF_ARG0   = 5'h14;
  localparam logic [4:0] OFF_ARG1   = 5'h18;
  localparam logic [4:0] OFF_RESULT = 5'h1C;

  // CTRL register bit positions
  localparam int CTRL_AP_START     = 0;
  localparam int CTRL_AP_DONE      = 1;
  localparam int CTRL_AP_IDLE      = 2;
  localparam int CTRL_AP_READY     = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Byte-lane merge of a write into an existing 32-bit register
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_dat,
                                              input logic [31:0] new_dat,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_dat[8*b +: 8] : old_dat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_ctrl_core_if.sv
// HLS block-control handshake: ap_start request, sticky ap_done, RESULT capture.
// Latency: all outputs registered, one cycle after the causing input.
// Backpressure: none; status inputs are sampled every cycle.
// Ports: clk/rst; ctrl_wr_vld + start/auto bits from a CTRL write; done_clr_vld
//        from a CTRL read; ap_done/ap_ready/result from the core; ap_start,
//        done_latch, auto_restart, result_dat back to the register bank.
module axi_lite_ctrl_core_if
  import axi_lite_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_wr_vld,
  input  logic        ctrl_wr_start,
  input  logic        ctrl_wr_auto,
  input  logic        done_clr_vld,
  input  logic        ap_done,
  input  logic        ap_ready,
  input  logic [31:0] result,
  output logic        ap_start,
  output logic        done_latch,
  output logic        auto_restart,
  output logic [31:0] result_dat
);

  logic        ap_start_q, ap_start_d;
  logic        done_q, done_d;
  logic        auto_q, auto_d;
  logic [31:0] result_q, result_d;

  always_comb begin
    ap_start_d = ap_start_q;
    done_d     = done_q;
    auto_d     = auto_q;
    result_d   = result_q;

    // Core accepted the start; keep requesting only in auto-restart mode.
    if (ap_ready && !auto_q) ap_start_d = 1'b0;
    // A fresh start request from software wins over the ap_ready clear.
    if (ctrl_wr_vld && ctrl_wr_start) ap_start_d = 1'b1;
    if (ctrl_wr_vld) auto_d = ctrl_wr_auto;

    // Clear-on-read, but a completion in the same cycle must not be lost.
    if (done_clr_vld) done_d = 1'b0;
    if (ap_done) begin
      done_d   = 1'b1;
      result_d = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ap_start_q <= 1'b0;
      done_q     <= 1'b0;
      auto_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      ap_start_q <= ap_start_d;
      done_q     <= done_d;
      auto_q     <= auto_d;
      result_q   <= result_d;
    end
  end

  assign ap_start     = ap_start_q;
  assign done_latch   = done_q;
  assign auto_restart = auto_q;
  assign result_dat   = result_q;

endmodule

// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite slave holding GP/CTRL/ARG/RESULT registers for an HLS core.
// Latency: B one cycle after the last of AW/W, R one cycle after AR.
// Backpressure: one write and one read outstanding; READYs drop while a B/R waits.
// Ports: ACLK/ARESET; S_AXI_* AXI4-Lite slave; ap_start/ap_done/ap_ready/ap_idle
//        core handshake; arg = {ARG2(=GP3), ARG1, ARG0}; result from core.
module axi_lite_ctrl_regs
  import axi_lite_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] RESET_ARG = 32'h0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_ready,
  input  logic              ap_idle,
  output logic [95:0]       arg,
  input  logic [31:0]       result
);

  // Write channel state
  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_held_q, w_held_d;
  logic [31:0]       w_dat_q, w_dat_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  resp_t             bresp_q, bresp_d;

  // Read channel state
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;

  // Register file
  logic [31:0]       gp_q [4];
  logic [31:0]       gp_d [4];
  logic [31:0]       arg0_q, arg0_d;
  logic [31:0]       arg1_q, arg1_d;

  // Core-interface wiring
  logic              done_latch, auto_restart;
  logic [31:0]       result_dat;
  logic              ctrl_wr_vld, done_clr_vld;
  logic [31:0]       ctrl_rd;

  // Handshakes and the effective write beat (held value or the one arriving now)
  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_dat;
  logic [3:0]        wr_strb;
  logic [4:0]        wr_off, rd_off;
  logic              wr_in_map, rd_in_map;

  assign aw_hs   = S_AXI_AWVALID && awready_q;
  assign w_hs    = S_AXI_WVALID  && wready_q;
  assign ar_hs   = S_AXI_ARVALID && arready_q;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_addr = aw_hs ? S_AXI_AWADDR : aw_addr_q;
  assign wr_dat  = w_hs  ? S_AXI_WDATA  : w_dat_q;
  assign wr_strb = w_hs  ? S_AXI_WSTRB  : w_strb_q;

  // Anything at or above 0x20 is outside the map (only reachable when ADDR_W > 5)
  assign wr_in_map = (wr_addr >> 5) == '0;
  assign rd_in_map = (S_AXI_ARADDR >> 5) == '0;
  assign wr_off    = {wr_addr[4:2], 2'b00};
  assign rd_off    = {S_AXI_ARADDR[4:2], 2'b00};

  assign ctrl_wr_vld  = commit && wr_in_map && (wr_off == OFF_CTRL) && wr_strb[0];
  assign done_clr_vld = ar_hs && rd_in_map && (rd_off == OFF_CTRL);

  always_comb begin
    ctrl_rd                    = '0;
    ctrl_rd[CTRL_AP_START]     = ap_start;
    ctrl_rd[CTRL_AP_DONE]      = done_latch;
    ctrl_rd[CTRL_AP_IDLE]      = ap_idle;
    ctrl_rd[CTRL_AP_READY]     = ap_ready;
    ctrl_rd[CTRL_AUTO_RESTART] = auto_restart;
  end

  // Write FSM: AW and W are captured independently, commit once both are in.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_dat_d   = w_dat_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    gp_d      = gp_q;
    arg0_d    = arg0_q;
    arg1_d    = arg1_q;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_map ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_map) begin
        // CTRL is handled in the core interface; RESULT writes are ignored.
        case (wr_off)
          OFF_GP0:  gp_d[0] = apply_wstrb(gp_q[0], wr_dat, wr_strb);
          OFF_GP1:  gp_d[1] = apply_wstrb(gp_q[1], wr_dat, wr_strb);
          OFF_GP2:  gp_d[2] = apply_wstrb(gp_q[2], wr_dat, wr_strb);
          OFF_GP3:  gp_d[3] = apply_wstrb(gp_q[3], wr_dat, wr_strb);
          OFF_ARG0: arg0_d  = apply_wstrb(arg0_q, wr_dat, wr_strb);
          OFF_ARG1: arg1_d  = apply_wstrb(arg1_q, wr_dat, wr_strb);
          default: ;
        endcase
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_dat_d  = S_AXI_WDATA;
        w_strb_d = S_AXI_WSTRB;
      end
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // Read FSM: data is sampled from current register values, so a write
  // committing on the same edge is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_in_map ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = '0;
      if (rd_in_map) begin
        case (rd_off)
          OFF_GP0:    rdata_d = gp_q[0];
          OFF_GP1:    rdata_d = gp_q[1];
          OFF_GP2:    rdata_d = gp_q[2];
          OFF_GP3:    rdata_d = gp_q[3];
          OFF_CTRL:   rdata_d = ctrl_rd;
          OFF_ARG0:   rdata_d = arg0_q;
          OFF_ARG1:   rdata_d = arg1_q;
          OFF_RESULT: rdata_d = result_dat;
          default:    rdata_d = '0;
        endcase
      end
    end

    arready_d = !rvalid_d;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < 4; i++) gp_q[i] <= '0;
      arg0_q    <= RESET_ARG;
      arg1_q    <= RESET_ARG;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_dat_q   <= w_dat_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      gp_q      <= gp_d;
      arg0_q    <= arg0_d;
      arg1_q    <= arg1_d;
    end
  end

  axi_lite_ctrl_core_if u_core_if (
    .clk           (ACLK),
    .rst           (ARESET),
    .ctrl_wr_vld   (ctrl_wr_vld),
    .ctrl_wr_start (wr_dat[CTRL_AP_START]),
    .ctrl_wr_auto  (wr_dat[CTRL_AUTO_RESTART]),
    .done_clr_vld  (done_clr_vld),
    .ap_done       (ap_done),
    .ap_ready      (ap_ready),
    .result        (result),
    .ap_start      (ap_start),
    .done_latch    (done_latch),
    .auto_restart  (auto_restart),
    .result_dat    (result_dat)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign arg           = {gp_q[3], arg1_q, arg0_q};

  // Protection attributes are accepted but carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
module tb_axi_lite_ctrl_regs;

  localparam int          ADDR_W    = 5;
  localparam logic [31:0] RESET_ARG = 32'h0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, result;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        ap_start, ap_done, ap_ready, ap_idle;
  logic [95:0] arg;

  axi_lite_ctrl_regs #(.ADDR_W(ADDR_W), .RESET_ARG(RESET_ARG)) dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
    .arg(arg), .result(result)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the register map as plain word storage plus control bits
  logic [31:0] m_reg [8];
  logic        m_start, m_auto, m_done;
  logic [31:0] m_result;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_reg[5] = RESET_ARG;
    m_reg[6] = RESET_ARG;
    m_start  = 1'b0;
    m_auto   = 1'b0;
    m_done   = 1'b0;
    m_result = 32'h0;
  endtask

  task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    logic [2:0]  idx;
    idx  = a[4:2];
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (idx == 3'd4) begin
      if (s[0]) begin
        if (d[0]) m_start = 1'b1;
        m_auto = d[7];
      end
    end else if (idx != 3'd7) begin
      m_reg[idx] = (m_reg[idx] & ~mask) | (d & mask);
    end
  endtask

  task automatic m_read(input logic [4:0] a, output logic [31:0] exp);
    logic [2:0] idx;
    idx = a[4:2];
    if (idx == 3'd4) begin
      exp = 32'(m_start) | (32'(m_done) << 1) | (32'(ap_idle) << 2) |
            (32'(ap_ready) << 3) | (32'(m_auto) << 7);
      m_done = 1'b0;
    end else if (idx == 3'd7) begin
      exp = m_result;
    end else begin
      exp = m_reg[idx];
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit finish_b,
                           output int aw_cyc);
    int cyc;
    bit aw_ok, w_ok, aw_fire, w_fire;
    cyc = 0; aw_ok = 0; w_ok = 0; aw_cyc = -1;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_ok && (cyc >= aw_dly);
      wvalid  = !w_ok && (cyc >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk);
      @(negedge clk);
      if (aw_fire) begin aw_ok = 1; aw_cyc = cyc; end
      if (w_fire) w_ok = 1;
      if (aw_ok != w_ok) begin
        check("bvalid_half", 32'(bvalid), 32'(0));
        check("awready_half", 32'(awready), 32'(!aw_ok));
        check("wready_half", 32'(wready), 32'(!w_ok));
      end
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("write_hs_done", 32'({aw_ok, w_ok}), 32'(2'b11));
    check("bvalid_after_hs", 32'(bvalid), 32'(1));
    check("bresp", 32'(bresp), 32'(0));
    m_write(a, d, s);
    if (finish_b) begin
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_clear", 32'(bvalid), 32'(0));
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input bit finish_r,
                          output logic [31:0] dat, output logic [1:0] resp);
    int cyc;
    bit fired;
    cyc = 0; fired = 0;
    araddr  = a;
    arvalid = 1'b1;
    while (!fired && cyc < 40) begin
      fired = arready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    arvalid = 1'b0;
    check("ar_hs_done", 32'(fired), 32'(1));
    check("rvalid_after_hs", 32'(rvalid), 32'(1));
    dat  = rdata;
    resp = rresp;
    if (finish_r) begin
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_clear", 32'(rvalid), 32'(0));
    end
  endtask

  task automatic read_check(input logic [4:0] a, input string tag, output logic [31:0] dat);
    logic [31:0] exp;
    logic [1:0]  resp;
    m_read(a, exp);
    axi_read(a, 1'b1, dat, resp);
    check(tag, dat, exp);
    check({tag, "_rresp"}, 32'(resp), 32'(0));
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ap_ready = 1'b0;
    if (!m_auto) m_start = 1'b0;
    check("ap_start_after_ready", 32'(ap_start), 32'(m_start));
  endtask

  task automatic pulse_done(input logic [31:0] r);
    ap_done = 1'b1;
    result  = r;
    @(posedge clk);
    @(negedge clk);
    ap_done  = 1'b0;
    m_done   = 1'b1;
    m_result = r;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  int          lc;
  logic [31:0] dat, exp, rnd;
  logic [1:0]  resp;
  logic [4:0]  a;
  int          op;

  initial begin
    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; result = '0;
    ap_done = 0; ap_ready = 0; ap_idle = 1;
    m_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", 32'(awready), 32'(0));
    check("rst_wready", 32'(wready), 32'(0));
    check("rst_arready", 32'(arready), 32'(0));
    check("rst_bvalid", 32'(bvalid), 32'(0));
    check("rst_rvalid", 32'(rvalid), 32'(0));
    check("rst_rdata", rdata, 32'(0));
    check("rst_resp", 32'({bresp, rresp}), 32'(0));
    check("rst_ap_start", 32'(ap_start), 32'(0));
    check("rst_arg0", arg[31:0], RESET_ARG);
    check("rst_arg2", arg[95:64], 32'(0));
    areset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_readys", 32'({awready, wready, arready}), 32'(3'b111));

    // GP write/readback
    for (int i = 0; i < 4; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 1'b1, lc);
    for (int i = 0; i < 4; i++) begin
      read_check(5'(i * 4), "gp_readback", dat);
      check("gp_literal", dat, 32'(i + 1));
    end

    // W three cycles ahead of AW
    axi_write(5'h14, 32'hDEADBEEF, 4'hF, 3, 0, 1'b1, lc);
    check("aw_late_cycle", 32'(lc), 32'(3));
    check("arg0_out", arg[31:0], 32'hDEADBEEF);

    // Byte strobes
    axi_write(5'h04, 32'h0, 4'hF, 0, 0, 1'b1, lc);
    axi_write(5'h04, 32'hFFFFFFFF, 4'b0101, 0, 1, 1'b1, lc);
    read_check(5'h04, "strb_model", dat);
    check("strb_literal", dat, 32'h00FF00FF);

    // Start / ready / done / clear-on-read
    axi_write(5'h10, 32'h1, 4'hF, 0, 0, 1'b1, lc);
    check("ap_start_set", 32'(ap_start), 32'(1));
    pulse_ready();
    check("ap_start_fell", 32'(ap_start), 32'(0));
    pulse_done(32'h1234);
    read_check(5'h10, "ctrl_done", dat);
    check("ctrl_done_literal", dat, 32'h6);
    read_check(5'h10, "ctrl_cleared", dat);
    check("ctrl_cleared_literal", dat, 32'h4);
    read_check(5'h1C, "result", dat);
    check("result_literal", dat, 32'h1234);

    // Auto-restart keeps ap_start; writing 0 to bit0 does not clear it
    axi_write(5'h10, 32'h81, 4'hF, 1, 0, 1'b1, lc);
    pulse_ready();
    check("auto_restart_hold", 32'(ap_start), 32'(1));
    axi_write(5'h10, 32'h0, 4'hF, 0, 0, 1'b1, lc);
    check("start_w0_noeffect", 32'(ap_start), 32'(1));
    pulse_ready();

    // Same-edge write commit and read of the same address returns the old value
    m_read(5'h08, exp);
    awaddr = 5'h08; wdata = 32'hA5A5A5A5; wstrb = 4'hF; araddr = 5'h08;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("rw_same_bvalid", 32'(bvalid), 32'(1));
    check("rw_same_old", rdata, exp);
    m_write(5'h08, 32'hA5A5A5A5, 4'hF);
    bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
    read_check(5'h08, "rw_same_new", dat);

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 9);
      a  = 5'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      if (op <= 3) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'b1, lc);
      end else if (op <= 6) begin
        read_check(a, "rand_read", dat);
      end else if (op == 7) begin
        pulse_ready();
      end else if (op == 8) begin
        pulse_done($urandom);
      end else begin
        check("rand_arg0", arg[31:0], m_reg[5]);
        check("rand_arg1", arg[63:32], m_reg[6]);
        check("rand_arg2", arg[95:64], m_reg[3]);
        check("rand_ap_start", 32'(ap_start), 32'(m_start));
        ap_idle = 1'($urandom_range(0, 1));
      end
    end

    // Stalled B and R, then reset in the middle of the wait
    axi_write(5'h10, 32'h1, 4'h1, 0, 0, 1'b1, lc);
    rnd = $urandom;
    axi_write(5'h00, rnd, 4'hF, 0, 0, 1'b0, lc);
    m_read(5'h18, exp);
    axi_read(5'h18, 1'b0, dat, resp);
    check("stall_first_rdata", dat, exp);
    awaddr = 5'h08; awvalid = 1; araddr = 5'h0C; arvalid = 1;
    for (int i = 0; i < 10; i++) begin
      check("stall_bvalid", 32'(bvalid), 32'(1));
      check("stall_rvalid", 32'(rvalid), 32'(1));
      check("stall_rdata", rdata, exp);
      check("stall_no_aw", 32'(awready), 32'(0));
      check("stall_no_ar", 32'(arready), 32'(0));
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_ap_start", 32'(ap_start), 32'(1));
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valids", 32'({bvalid, rvalid}), 32'(0));
    check("midrst_readys", 32'({awready, wready, arready}), 32'(0));
    check("midrst_rdata", rdata, 32'(0));
    check("midrst_resp", 32'({bresp, rresp}), 32'(0));
    check("midrst_ap_start", 32'(ap_start), 32'(0));
    awvalid = 0; arvalid = 0;
    areset  = 1'b0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    read_check(5'h00, "post_rst_gp0", dat);
    read_check(5'h14, "post_rst_arg0", dat);
    read_check(5'h10, "post_rst_ctrl", dat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
